// File: rtl/mfp_ahb_cmd_master.sv
// AHB-Lite bus master: turns a command/data stream into SINGLE or INCR bursts of 1..2^LEN_W
// beats, with one data phase overlapping the next address phase. An ERROR response aborts the command.
module mfp_ahb_cmd_master #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  output logic [31:0]      HADDR,
  output logic [2:0]       HBURST,
  output logic             HMASTLOCK,
  output logic [3:0]       HPROT,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [1:0]       cmd_size,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] StIdle = 2'd0, StRun = 2'd1, StDrain = 2'd2, StErr2 = 2'd3;
  localparam logic [1:0] TrIdle = 2'b00, TrBusy = 2'b01, TrNonseq = 2'b10, TrSeq = 2'b11;
  localparam int unsigned CntW = LEN_W + 1;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] beats_left_q, beats_left_d;  // beats whose address phase is not yet accepted
  logic [CntW-1:0] fetch_left_q, fetch_left_d;
  logic            first_q, first_d;            // no beat of this command issued yet
  logic            dph_q, dph_d;                // a data phase is outstanding
  logic [31:0]     wbuf_q, wbuf_d;
  logic            wbuf_full_q, wbuf_full_d;
  logic [31:0]     aph_wdata_q, aph_wdata_d;    // write data of the beat in its address phase
  logic [31:0]     haddr_d, hwdata_d, rd_data_d;
  logic [2:0]      hburst_d, hsize_d;
  logic [1:0]      htrans_d;
  logic            hwrite_d, rd_valid_d, done_d, err_d;

  logic [1:0]      size_eff;
  logic [31:0]     cmd_addr_al, next_addr, issue_addr;
  logic            accept, slot_free, wr_fire, have_data, err_hit, dph_done;
  logic [CntW-1:0] remaining;

  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

  assign size_eff = (cmd_size == 2'd3) ? 2'd2 : cmd_size;

  always_comb begin
    unique case (size_eff)
      2'd0:    cmd_addr_al = cmd_addr;
      2'd1:    cmd_addr_al = {cmd_addr[31:1], 1'b0};
      default: cmd_addr_al = {cmd_addr[31:2], 2'b00};
    endcase
  end

  assign cmd_ready  = (state_q == StIdle);
  assign wr_ready   = (state_q == StRun) && HWRITE && !wbuf_full_q && (fetch_left_q != '0);
  assign wr_fire    = wr_valid && wr_ready;
  assign accept     = (state_q == StRun) && HTRANS[1] && HREADY;
  // A NONSEQ/SEQ must hold until HREADY; IDLE/BUSY may change at any time.
  assign slot_free  = !HTRANS[1] || HREADY;
  assign remaining  = beats_left_q - CntW'(accept);
  assign next_addr  = HADDR + (32'd1 << HSIZE[1:0]);
  assign issue_addr = accept ? next_addr : HADDR;
  assign have_data  = !HWRITE || wbuf_full_q || wr_fire;
  assign err_hit    = dph_q && HRESP;
  assign dph_done   = dph_q && HREADY && !HRESP;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    fetch_left_d = fetch_left_q;
    first_d      = first_q;
    dph_d        = HREADY ? accept : dph_q;
    wbuf_d       = wbuf_q;
    wbuf_full_d  = wbuf_full_q;
    aph_wdata_d  = aph_wdata_q;
    haddr_d      = HADDR;
    hburst_d     = HBURST;
    hsize_d      = HSIZE;
    htrans_d     = HTRANS;
    hwrite_d     = HWRITE;
    hwdata_d     = HWDATA;
    rd_data_d    = rd_data;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (dph_done && !HWRITE) begin
      rd_data_d  = HRDATA;
      rd_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d      = StRun;
          haddr_d      = cmd_addr_al;
          hsize_d      = {1'b0, size_eff};
          hburst_d     = (cmd_len == '0) ? 3'b000 : 3'b001;
          hwrite_d     = cmd_write;
          htrans_d     = cmd_write ? TrIdle : TrNonseq;
          beats_left_d = CntW'(cmd_len) + CntW'(1);
          fetch_left_d = cmd_write ? CntW'(cmd_len) + CntW'(1) : '0;
          first_d      = cmd_write;
          wbuf_full_d  = 1'b0;
        end
      end
      StRun: begin
        if (wr_fire) fetch_left_d = fetch_left_q - CntW'(1);
        if (accept) begin
          hwdata_d     = aph_wdata_q;
          beats_left_d = remaining;
        end
        if (accept && remaining == '0) begin
          state_d  = StDrain;
          htrans_d = TrIdle;
        end else if (slot_free) begin
          haddr_d = issue_addr;
          if (have_data) begin
            // A new 1 KB region restarts the burst with NONSEQ.
            htrans_d    = (first_q || issue_addr[9:0] == 10'd0) ? TrNonseq : TrSeq;
            first_d     = 1'b0;
            aph_wdata_d = wbuf_full_q ? wbuf_q : wr_data;
            wbuf_full_d = 1'b0;
          end else begin
            htrans_d = first_q ? TrIdle : TrBusy;
          end
        end else if (wr_fire) begin
          wbuf_d      = wr_data;
          wbuf_full_d = 1'b1;
        end
      end
      StDrain: begin
        if (dph_done) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StErr2: begin
        if (HREADY) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
    endcase

    // ERROR overrides everything: cancel the pending address and drop the rest of the command.
    if (err_hit) begin
      htrans_d     = TrIdle;
      dph_d        = 1'b0;
      wbuf_full_d  = 1'b0;
      fetch_left_d = '0;
      beats_left_d = '0;
      if (HREADY) begin
        state_d = StIdle;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        state_d = StErr2;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StIdle;
      beats_left_q <= '0;
      fetch_left_q <= '0;
      first_q      <= 1'b0;
      dph_q        <= 1'b0;
      wbuf_q       <= '0;
      wbuf_full_q  <= 1'b0;
      aph_wdata_q  <= '0;
      HADDR        <= '0;
      HBURST       <= '0;
      HSIZE        <= '0;
      HTRANS       <= TrIdle;
      HWRITE       <= 1'b0;
      HWDATA       <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      fetch_left_q <= fetch_left_d;
      first_q      <= first_d;
      dph_q        <= dph_d;
      wbuf_q       <= wbuf_d;
      wbuf_full_q  <= wbuf_full_d;
      aph_wdata_q  <= aph_wdata_d;
      HADDR        <= haddr_d;
      HBURST       <= hburst_d;
      HSIZE        <= hsize_d;
      HTRANS       <= htrans_d;
      HWRITE       <= hwrite_d;
      HWDATA       <= hwdata_d;
      rd_data      <= rd_data_d;
      rd_valid     <= rd_valid_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_cmd_master.sv
// Directed bench for mfp_ahb_cmd_master: the bench plays the AHB slave cycle by cycle and
// checks bus and stream outputs against hand-computed schedules.
module tb_mfp_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, done, err;
  logic [31:0] rd_data;

  int ncmp = 0;
  int nfail = 0;

  mfp_ahb_cmd_master #(.LEN_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick();
    tick();
    ncmp++; if (HTRANS !== 2'b00) begin nfail++; $display("FAIL rst_htrans got %b exp 00", HTRANS); end
    ncmp++; if (HADDR !== 32'h0) begin nfail++; $display("FAIL rst_haddr got %h exp 0", HADDR); end
    ncmp++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    ncmp++; if (wr_ready !== 1'b0) begin nfail++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
    ncmp++; if (HPROT !== 4'b0011) begin nfail++; $display("FAIL rst_hprot got %b exp 0011", HPROT); end
    ncmp++; if (HMASTLOCK !== 1'b0) begin nfail++; $display("FAIL rst_hmastlock got %b exp 0", HMASTLOCK); end
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ncmp++; if (done !== 1'b0 || rd_valid !== 1'b0) begin
        nfail++; $display("FAIL idle_quiet got done=%b rd_valid=%b exp 0/0", done, rd_valid);
      end
    end
  endtask

  task automatic test_single_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1F80_0000; cmd_size = 2'd2; cmd_len = 4'd0;
    tick(); // cycle 1
    cmd_valid = 1'b0;
    ncmp++; if (HTRANS !== 2'b10) begin nfail++; $display("FAIL sr_htrans got %b exp 10", HTRANS); end
    ncmp++; if (HADDR !== 32'h1F80_0000) begin nfail++; $display("FAIL sr_haddr got %h exp 1f800000", HADDR); end
    ncmp++; if (HBURST !== 3'b000 || HSIZE !== 3'b010 || HWRITE !== 1'b0) begin
      nfail++; $display("FAIL sr_ctrl got burst=%b size=%b write=%b exp 000/010/0", HBURST, HSIZE, HWRITE);
    end
    ncmp++; if (cmd_ready !== 1'b0) begin nfail++; $display("FAIL sr_busy_ready got %b exp 0", cmd_ready); end
    tick(); // cycle 2: data phase
    HRDATA = 32'hDEAD_BEEF;
    ncmp++; if (HTRANS !== 2'b00) begin nfail++; $display("FAIL sr_drain_htrans got %b exp 00", HTRANS); end
    tick(); // cycle 3
    HRDATA = 32'h0;
    ncmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF) begin
      nfail++; $display("FAIL sr_rdata got v=%b d=%h exp 1/deadbeef", rd_valid, rd_data);
    end
    ncmp++; if (done !== 1'b1 || err !== 1'b0) begin
      nfail++; $display("FAIL sr_done got done=%b err=%b exp 1/0", done, err);
    end
    ncmp++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL sr_ready_back got %b exp 1", cmd_ready); end
    tick(); // cycle 4
    ncmp++; if (rd_valid !== 1'b0 || done !== 1'b0) begin
      nfail++; $display("FAIL sr_pulse got v=%b done=%b exp 0/0", rd_valid, done);
    end
  endtask

  task automatic test_burst_write();
    logic [1:0]  exp_tr [1:8];
    logic [31:0] exp_ad [1:8];
    logic [31:0] w [0:3];
    w[0] = 32'h1111_0000; w[1] = 32'h2222_0001; w[2] = 32'h3333_0002; w[3] = 32'h4444_0003;
    exp_tr[1] = 2'b00; exp_tr[2] = 2'b10; exp_tr[3] = 2'b11; exp_tr[4] = 2'b01;
    exp_tr[5] = 2'b01; exp_tr[6] = 2'b11; exp_tr[7] = 2'b11; exp_tr[8] = 2'b00;
    exp_ad[1] = 32'h100; exp_ad[2] = 32'h100; exp_ad[3] = 32'h104; exp_ad[4] = 32'h108;
    exp_ad[5] = 32'h108; exp_ad[6] = 32'h108; exp_ad[7] = 32'h10C; exp_ad[8] = 32'h10C;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_size = 2'd2; cmd_len = 4'd3;
    for (int c = 1; c <= 9; c++) begin
      tick();
      cmd_valid = 1'b0;
      if (c <= 8) begin
        ncmp++; if (HTRANS !== exp_tr[c]) begin
          nfail++; $display("FAIL bw_htrans c%0d got %b exp %b", c, HTRANS, exp_tr[c]);
        end
      end
      if (c >= 2 && c <= 7 && exp_tr[c] != 2'b01) begin
        ncmp++; if (HADDR !== exp_ad[c]) begin
          nfail++; $display("FAIL bw_haddr c%0d got %h exp %h", c, HADDR, exp_ad[c]);
        end
      end
      if (c == 2) begin
        ncmp++; if (HBURST !== 3'b001 || HWRITE !== 1'b1) begin
          nfail++; $display("FAIL bw_ctrl got burst=%b write=%b exp 001/1", HBURST, HWRITE);
        end
      end
      if (c == 3 || c == 4 || c == 7 || c == 8) begin
        logic [31:0] ew;
        ew = (c == 3) ? w[0] : (c == 4) ? w[1] : (c == 7) ? w[2] : w[3];
        ncmp++; if (HWDATA !== ew) begin
          nfail++; $display("FAIL bw_hwdata c%0d got %h exp %h", c, HWDATA, ew);
        end
      end
      if (c == 7) begin
        ncmp++; if (wr_ready !== 1'b0) begin nfail++; $display("FAIL bw_wr_ready_end got %b exp 0", wr_ready); end
      end
      if (c == 9) begin
        ncmp++; if (done !== 1'b1 || err !== 1'b0) begin
          nfail++; $display("FAIL bw_done got done=%b err=%b exp 1/0", done, err);
        end
      end
      // wr_valid schedule: words 0,1 in cycles 1-2, low in 3-4, words 2,3 in cycles 5-6
      wr_valid = (c == 1 || c == 2 || c == 5 || c == 6);
      wr_data  = (c == 1) ? w[0] : (c == 2) ? w[1] : (c == 5) ? w[2] : (c == 6) ? w[3] : 32'h0;
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_wait_states();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2000; cmd_size = 2'd2; cmd_len = 4'd1;
    tick(); // cycle 1
    cmd_valid = 1'b0;
    ncmp++; if (HTRANS !== 2'b10 || HADDR !== 32'h2000) begin
      nfail++; $display("FAIL ws_beat1 got %b/%h exp 10/00002000", HTRANS, HADDR);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      HREADY = (c == 5);
      HRDATA = (c == 5) ? 32'hAAAA_0001 : 32'h0;
      ncmp++; if (HTRANS !== 2'b11 || HADDR !== 32'h2004) begin
        nfail++; $display("FAIL ws_hold c%0d got %b/%h exp 11/00002004", c, HTRANS, HADDR);
      end
      if (c >= 3) begin
        ncmp++; if (rd_valid !== 1'b0) begin nfail++; $display("FAIL ws_no_rd c%0d got %b exp 0", c, rd_valid); end
      end
    end
    tick(); // cycle 6
    HRDATA = 32'hBBBB_0002;
    ncmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hAAAA_0001 || done !== 1'b0) begin
      nfail++; $display("FAIL ws_rd1 got v=%b d=%h done=%b exp 1/aaaa0001/0", rd_valid, rd_data, done);
    end
    tick(); // cycle 7
    HRDATA = 32'h0;
    ncmp++; if (rd_valid !== 1'b1 || rd_data !== 32'hBBBB_0002 || done !== 1'b1) begin
      nfail++; $display("FAIL ws_rd2 got v=%b d=%h done=%b exp 1/bbbb0002/1", rd_valid, rd_data, done);
    end
  endtask

  task automatic test_kb_cross();
    logic [31:0] ea [1:4];
    logic [1:0]  et [1:4];
    ea[1] = 32'h3FE; ea[2] = 32'h3FF; ea[3] = 32'h400; ea[4] = 32'h401;
    et[1] = 2'b10;   et[2] = 2'b11;   et[3] = 2'b10;   et[4] = 2'b11;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3FE; cmd_size = 2'd0; cmd_len = 4'd3;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cmd_valid = 1'b0;
      HRDATA = 32'h0000_0A00 + c;
      if (c <= 4) begin
        ncmp++; if (HTRANS !== et[c] || HADDR !== ea[c]) begin
          nfail++; $display("FAIL kb_addr c%0d got %b/%h exp %b/%h", c, HTRANS, HADDR, et[c], ea[c]);
        end
      end
      if (c == 1) begin
        ncmp++; if (HSIZE !== 3'b000 || HBURST !== 3'b001) begin
          nfail++; $display("FAIL kb_ctrl got size=%b burst=%b exp 000/001", HSIZE, HBURST);
        end
      end
      if (c >= 3) begin
        ncmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0A00 + c - 1) begin
          nfail++; $display("FAIL kb_rd c%0d got v=%b d=%h exp 1/%h", c, rd_valid, rd_data, 32'hA00 + c - 1);
        end
      end
      ncmp++; if (done !== (c == 6)) begin
        nfail++; $display("FAIL kb_done c%0d got %b exp %b", c, done, (c == 6));
      end
    end
    HRDATA = 32'h0;
  endtask

  task automatic test_error();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_size = 2'd2; cmd_len = 4'd7;
    for (int c = 1; c <= 8; c++) begin
      tick();
      cmd_valid = 1'b0;
      if (c == 2 || c == 3 || c == 4 || c == 5) begin
        logic [31:0] ea;
        ea = 32'h500 + 32'((c - 2) * 4);
        ncmp++; if (HTRANS !== ((c == 2) ? 2'b10 : 2'b11) || HADDR !== ea) begin
          nfail++; $display("FAIL er_addr c%0d got %b/%h exp addr %h", c, HTRANS, HADDR, ea);
        end
      end
      if (c == 5) begin
        ncmp++; if (HWDATA !== 32'hE000_0002) begin
          nfail++; $display("FAIL er_hwdata got %h exp e0000002", HWDATA);
        end
      end
      if (c >= 6) begin
        ncmp++; if (HTRANS !== 2'b00) begin nfail++; $display("FAIL er_htrans c%0d got %b exp 00", c, HTRANS); end
        ncmp++; if (wr_ready !== 1'b0) begin nfail++; $display("FAIL er_wr_ready c%0d got %b exp 0", c, wr_ready); end
      end
      if (c == 6 || c == 8) begin
        ncmp++; if (done !== 1'b0) begin nfail++; $display("FAIL er_no_done c%0d got %b exp 0", c, done); end
      end
      if (c == 7) begin
        ncmp++; if (done !== 1'b1 || err !== 1'b1 || rd_valid !== 1'b0) begin
          nfail++; $display("FAIL er_done got done=%b err=%b rdv=%b exp 1/1/0", done, err, rd_valid);
        end
        ncmp++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL er_ready got %b exp 1", cmd_ready); end
      end
      wr_valid = 1'b1;
      wr_data  = 32'hE000_0000 + (c - 1);
      HRESP    = (c == 5 || c == 6);
      HREADY   = (c != 5);
    end
    wr_valid = 1'b0;
    HRESP = 1'b0;
    HREADY = 1'b1;
    // next command: single halfword write at an unaligned address
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h603; cmd_size = 2'd1; cmd_len = 4'd0;
    tick(); // cycle 1
    cmd_valid = 1'b0;
    ncmp++; if (HTRANS !== 2'b00 || wr_ready !== 1'b1) begin
      nfail++; $display("FAIL rc_wait got %b/%b exp 00/1", HTRANS, wr_ready);
    end
    wr_valid = 1'b1; wr_data = 32'h0000_CAFE;
    tick(); // cycle 2
    wr_valid = 1'b0;
    ncmp++; if (HTRANS !== 2'b10 || HADDR !== 32'h602 || HSIZE !== 3'b001 || HBURST !== 3'b000) begin
      nfail++; $display("FAIL rc_addr got %b/%h/%b/%b exp 10/00000602/001/000", HTRANS, HADDR, HSIZE, HBURST);
    end
    tick(); // cycle 3
    ncmp++; if (HWDATA !== 32'h0000_CAFE) begin nfail++; $display("FAIL rc_hwdata got %h exp 0000cafe", HWDATA); end
    tick(); // cycle 4
    ncmp++; if (done !== 1'b1 || err !== 1'b0) begin
      nfail++; $display("FAIL rc_done got done=%b err=%b exp 1/0", done, err);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000; cmd_size = 2'd2; cmd_len = 4'd15;
    for (int c = 1; c <= 5; c++) begin
      tick();
      cmd_valid = 1'b0;
      HRDATA = 32'h0000_1000 + c;
      ncmp++; if (HADDR !== 32'h8000 + 32'((c - 1) * 4)) begin
        nfail++; $display("FAIL rm_addr c%0d got %h exp %h", c, HADDR, 32'h8000 + 32'((c - 1) * 4));
      end
    end
    HRESETn = 1'b0;
    #1;
    ncmp++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HSIZE !== 3'b000 || HBURST !== 3'b000) begin
      nfail++; $display("FAIL rm_bus got %b/%h/%b/%b exp all 0", HTRANS, HADDR, HSIZE, HBURST);
    end
    ncmp++; if (HWDATA !== 32'h0 || HWRITE !== 1'b0) begin
      nfail++; $display("FAIL rm_wr got %h/%b exp 0/0", HWDATA, HWRITE);
    end
    ncmp++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
      nfail++; $display("FAIL rm_stream got %b/%h/%b/%b exp all 0", rd_valid, rd_data, done, err);
    end
    tick();
    ncmp++; if (HTRANS !== 2'b00) begin nfail++; $display("FAIL rm_hold got %b exp 00", HTRANS); end
    HRESETn = 1'b1;
    HRDATA = 32'h0;
    tick();
    ncmp++; if (cmd_ready !== 1'b1 || HTRANS !== 2'b00 || rd_valid !== 1'b0) begin
      nfail++; $display("FAIL rm_idle got %b/%b/%b exp 1/00/0", cmd_ready, HTRANS, rd_valid);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_size = 2'd2; cmd_len = 4'd0;
    tick(); // cycle 1
    cmd_valid = 1'b0;
    ncmp++; if (HTRANS !== 2'b10 || HADDR !== 32'h44) begin
      nfail++; $display("FAIL rm_new_addr got %b/%h exp 10/00000044", HTRANS, HADDR);
    end
    tick(); // cycle 2
    HRDATA = 32'h1234_5678;
    tick(); // cycle 3
    HRDATA = 32'h0;
    ncmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678 || done !== 1'b1 || err !== 1'b0) begin
      nfail++; $display("FAIL rm_new_rd got %b/%h/%b/%b exp 1/12345678/1/0", rd_valid, rd_data, done, err);
    end
  endtask

  initial begin
    HRESETn = 1'b0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 2'd0; cmd_len = 4'd0;
    wr_valid = 1'b0; wr_data = 32'h0;
    test_reset();
    test_single_read();
    test_burst_write();
    test_wait_states();
    test_kb_cross();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
